vx_skid_pipe: RTL

VX_SKID_PIPE -- requirements
Module: VX_skid_pipe

---
 rtl/vx_skid_pipe_pkg.sv | 8 +
 rtl/vx_skid_stage.sv | 93 +++++++++
 rtl/vx_skid_pipe.sv | 57 +++++
 3 files changed

// File: rtl/vx_skid_pipe_pkg.sv
// Shared helpers for the skid pipe slice. Stage state encoding stays local to the stage.
package vx_skid_pipe_pkg;

  function automatic int cdiv(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/vx_skid_stage.sv
// One registered handshake stage: main + skid payload registers, fully registered
// valid_out/data_out and a registered ready_in.
module vx_skid_stage
  import vx_skid_pipe_pkg::*;
#(
  parameter int DATAW  = 1,
  parameter int RESETW = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out,
  output logic [1:0]       state_o
);

  // Handshake: a side transfers only in a cycle where its valid and ready are both high.
  // Bit 0 of the state means "main held", bit 1 means "skid held".
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  localparam logic [DATAW-1:0] RST_MASK = ~({DATAW{1'b1}} >> RESETW);

  state_e           state_q, state_d;
  logic [DATAW-1:0] main_q, main_d;
  logic [DATAW-1:0] skid_q, skid_d;
  logic             fire_in, fire_out;

  assign ready_in  = ~state_q[1];
  assign valid_out = state_q[0];
  assign data_out  = main_q;
  assign state_o   = state_q;

  assign fire_in  = valid_in & ready_in;
  assign fire_out = valid_out & ready_out;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (fire_in) begin
          state_d = ST_BUSY;
          main_d  = data_in;
        end
      end
      ST_BUSY: begin
        if (fire_in && fire_out) begin
          main_d = data_in;
        end else if (fire_in) begin
          state_d = ST_FULL;
          skid_d  = data_in;
        end else if (fire_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (fire_out) begin
          state_d = ST_BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Only the top RESETW payload bits are cleared; the rest simply hold during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= main_q & ~RST_MASK;
      skid_q <= skid_q & ~RST_MASK;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: rtl/vx_skid_pipe.sv
// Chain of DEPTH skid stages; DEPTH=0 collapses to a combinational pass-through.
module vx_skid_pipe
  import vx_skid_pipe_pkg::*;
#(
  parameter int DATAW  = 1,
  parameter int DEPTH  = 1,
  parameter int RESETW = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign valid_out = valid_in;
    assign data_out  = data_in;
    assign ready_in  = ready_out;
  end else begin : g_pipe
    // Index k is the input side of stage k; index DEPTH is the pipe output.
    logic             valid_c [DEPTH+1];
    logic [DATAW-1:0] data_c  [DEPTH+1];
    logic             ready_c [DEPTH+1];
    logic [2*DEPTH-1:0] unused_state;

    assign valid_c[0]     = valid_in;
    assign data_c[0]      = data_in;
    assign ready_in       = ready_c[0];
    assign valid_out      = valid_c[DEPTH];
    assign data_out       = data_c[DEPTH];
    assign ready_c[DEPTH] = ready_out;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      vx_skid_stage #(
        .DATAW  (DATAW),
        .RESETW (RESETW)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_c[k]),
        .data_in   (data_c[k]),
        .ready_in  (ready_c[k]),
        .valid_out (valid_c[k+1]),
        .data_out  (data_c[k+1]),
        .ready_out (ready_c[k+1]),
        .state_o   (unused_state[2*k +: 2])
      );
    end
  end

endmodule
